// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings and constants for the EX-stage multiply/divide unit
package mips_pkg;
  typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} md_op_e;
  typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIX} md_state_e;
  localparam int MD_ITERS = 32;
  localparam int MD_LATENCY = 34;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV = 6'h1A;
  localparam logic [5:0] FN_DIVU = 6'h1B;
endpackage

// File: rtl/md_sign_fix.sv
// md_sign_fix: conditional two's-complement negate
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);
  assign y = neg ? -x : x;
endmodule

// File: rtl/mul_div_sequencer.sv
// mul_div_sequencer: iterative radix-2 MULT/MULTU/DIV/DIVU engine owning HI/LO
module mul_div_sequencer
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             MfHi,
  input  logic             MfLo,
  input  logic             MtHi,
  input  logic             MtLo,
  input  logic             Flush,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int CW = $clog2(MD_ITERS);
  md_state_e state, next;
  md_op_e op_q;
  logic [WIDTH-1:0] a_q, b_q, ma, mb, abs_a, abs_b, quo_f, rem_f, rem;
  logic [2*WIDTH-1:0] acc, prod_f;
  logic [WIDTH:0] sum, part;
  logic [CW-1:0] cnt;
  logic psign, rsign, is_div, is_sgn, last, dbz, ge;
  assign is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign is_sgn = (op_q == OP_MULT) || (op_q == OP_DIV);
  assign last = cnt == CW'(MD_ITERS - 1);
  assign dbz = is_div && (b_q == '0);
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mb[0] ? ma : '0};
  assign part = {rem, ma[WIDTH-1]};
  assign ge = part >= {1'b0, mb};
  md_sign_fix #(.W(WIDTH)) u_abs_a (.x(a_q), .neg(is_sgn & a_q[WIDTH-1]), .y(abs_a));
  md_sign_fix #(.W(WIDTH)) u_abs_b (.x(b_q), .neg(is_sgn & b_q[WIDTH-1]), .y(abs_b));
  md_sign_fix #(.W(2*WIDTH)) u_fix_p (.x(acc), .neg(psign), .y(prod_f));
  md_sign_fix #(.W(WIDTH)) u_fix_q (.x(ma), .neg(psign), .y(quo_f));
  md_sign_fix #(.W(WIDTH)) u_fix_r (.x(rem), .neg(rsign), .y(rem_f));
  // state register
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) state <= S_IDLE;
    else state <= next;
  // next-state, busy and stall decode
  always_comb begin
    next = state;
    case (state)
      S_IDLE: next = Start ? S_PREP : S_IDLE;
      S_PREP: next = S_ITER;
      S_ITER: next = last ? S_FIX : S_ITER;
      default: next = S_IDLE;
    endcase
    if (Flush) next = S_IDLE;
    Busy = state != S_IDLE;
    Stall = Busy & (MfHi | MfLo | MtHi | MtLo | Start);
  end
  // operand capture, shift-add / restoring-divide datapath and HI/LO commit
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      op_q <= OP_MULT;
      a_q <= '0;
      b_q <= '0;
      ma <= '0;
      mb <= '0;
      acc <= '0;
      rem <= '0;
      cnt <= '0;
      psign <= 1'b0;
      rsign <= 1'b0;
      Done <= 1'b0;
      DivByZero <= 1'b0;
      HI <= '0;
      LO <= '0;
    end else begin
      Done <= 1'b0;
      DivByZero <= 1'b0;
      case (state)
        S_IDLE: if (!Flush) begin
          if (Start) begin
            op_q <= md_op_e'(Op);
            a_q <= A;
            b_q <= B;
          end
          if (MtHi) HI <= A;
          if (MtLo) LO <= A;
        end
        S_PREP: begin
          ma <= abs_a;
          mb <= abs_b;
          psign <= is_sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          rsign <= is_sgn & a_q[WIDTH-1];
          acc <= '0;
          rem <= '0;
          cnt <= '0;
        end
        S_ITER: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            rem <= ge ? WIDTH'(part - {1'b0, mb}) : part[WIDTH-1:0];
            ma <= {ma[WIDTH-2:0], ge};
          end else begin
            acc <= {sum, acc[WIDTH-1:1]};
            mb <= mb >> 1;
          end
        end
        default: if (!Flush) begin
          Done <= 1'b1;
          DivByZero <= dbz;
          HI <= dbz ? a_q : (is_div ? rem_f : prod_f[2*WIDTH-1:WIDTH]);
          LO <= dbz ? '1 : (is_div ? quo_f : prod_f[WIDTH-1:0]);
        end
      endcase
    end
endmodule

// File: tb/tb_mul_div_sequencer.sv
// tb_mul_div_sequencer: scoreboard bench with arithmetic reference model
module tb_mul_div_sequencer;
  logic Clk = 0, Rst_n = 0, Start = 0, MfHi = 0, MfLo = 0, MtHi = 0, MtLo = 0, Flush = 0;
  logic [1:0] Op = 0;
  logic [31:0] A = 0, B = 0;
  logic Busy, Stall, Done, DivByZero;
  logic [31:0] HI, LO;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic dbz;
    int issue;
  } exp_t;
  exp_t scb[$];
  mul_div_sequencer #(.WIDTH(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op), .A(A), .B(B),
    .MfHi(MfHi), .MfLo(MfLo), .MtHi(MtHi), .MtLo(MtLo), .Flush(Flush),
    .Busy(Busy), .Stall(Stall), .Done(Done), .DivByZero(DivByZero), .HI(HI), .LO(LO)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask
  task automatic timeout_fail(string name);
    checks++;
    errors++;
    $display("FAIL %s: got no Done within budget required Done", name);
  endtask
  function automatic exp_t model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    exp_t e;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint p;
    e.dbz = 0;
    e.issue = 0;
    e.hi = 0;
    e.lo = 0;
    if (op == 2'b00) begin
      p = sa * sb;
      {e.hi, e.lo} = p;
    end else if (op == 2'b01) {e.hi, e.lo} = ua * ub;
    else if (b == 0) begin
      e.dbz = 1;
      e.hi = a;
      e.lo = 32'hFFFF_FFFF;
    end else if (op == 2'b10) begin
      e.lo = 32'(sa / sb);
      e.hi = 32'(sa % sb);
    end else begin
      e.lo = 32'(ua / ub);
      e.hi = 32'(ua % ub);
    end
    return e;
  endfunction
  always @(negedge Clk) begin
    if (Rst_n && DivByZero && !Done) chk("dbz_without_done", 1, 0);
    if (Rst_n && Done) begin
      if (scb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Done=1 required no pending result");
      end else begin
        exp_t e;
        e = scb.pop_front();
        chk("hi", HI, e.hi);
        chk("lo", LO, e.lo);
        chk("divbyzero", DivByZero, e.dbz);
        chk("latency", 64'(cyc - e.issue), 35);
      end
    end
  end
  task automatic issue(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    exp_t e;
    e = model(op, a, b);
    e.issue = cyc;
    scb.push_back(e);
    Op = op;
    A = a;
    B = b;
    Start = 1;
    @(negedge Clk);
    Start = 0;
  endtask
  task automatic wait_done(string name);
    int n = 0;
    while (!Done && n < 60) begin
      @(negedge Clk);
      n++;
    end
    if (!Done) timeout_fail(name);
  endtask
  task automatic mf_test(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    exp_t e;
    int n = 0;
    bit seen = 0;
    e = model(op, a, b);
    issue(op, a, b);
    MfLo = 1;
    while (!seen && n < 60) begin
      #1;
      if (Done) begin
        chk("stall_at_done", Stall, 0);
        chk("lo_at_done", LO, e.lo);
        seen = 1;
      end else begin
        chk("stall_mflo", Stall, 1);
        @(negedge Clk);
        n++;
      end
    end
    if (!seen) timeout_fail("mf_done");
    MfLo = 0;
    @(negedge Clk);
  endtask
  task automatic mt_test(logic [31:0] a1, logic [31:0] b1, logic [31:0] a2, logic [31:0] b2);
    exp_t e;
    int n = 0;
    bit seen = 0;
    issue(2'b00, a1, b1);
    MtHi = 1;
    Start = 1;
    Op = 2'b11;
    A = a2;
    B = b2;
    while (!seen && n < 60) begin
      #1;
      if (Done) begin
        chk("stall_mt_at_done", Stall, 0);
        e = model(2'b11, a2, b2);
        e.issue = cyc;
        scb.push_back(e);
        seen = 1;
      end else begin
        chk("stall_mt_start", Stall, 1);
        @(negedge Clk);
        n++;
      end
    end
    if (!seen) timeout_fail("mt_done");
    @(negedge Clk);
    MtHi = 0;
    Start = 0;
    chk("mthi_accepted", HI, a2);
    chk("start_accepted", Busy, 1);
    wait_done("mt_second");
    @(negedge Clk);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    logic [1:0] dop[6] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b10};
    logic [31:0] da[6] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000, 32'd100, 32'hFFFF_FFFB};
    logic [31:0] db[6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0};
    repeat (3) @(negedge Clk);
    Start = 1;
    #1;
    chk("rst_hi", HI, 0);
    chk("rst_lo", LO, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_stall", Stall, 0);
    chk("rst_done", Done, 0);
    chk("rst_dbz", DivByZero, 0);
    Start = 0;
    @(negedge Clk);
    Rst_n = 1;
    @(negedge Clk);
    issue(dop[0], da[0], db[0]);
    wait_done("mult_first");
    @(negedge Clk);
    chk("done_single_pulse", Done, 0);
    for (int i = 1; i < 6; i++) begin
      issue(dop[i], da[i], db[i]);
      wait_done("directed");
    end
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom);
      issue(op, a, b);
      wait_done("random");
    end
    @(negedge Clk);
    MtHi = 1;
    A = 32'h11;
    @(negedge Clk);
    MtHi = 0;
    MtLo = 1;
    A = 32'h22;
    @(negedge Clk);
    MtLo = 0;
    chk("mthi_idle", HI, 32'h11);
    chk("mtlo_idle", LO, 32'h22);
    Op = 2'b00;
    A = 5;
    B = 6;
    Start = 1;
    @(negedge Clk);
    Start = 0;
    repeat (11) @(negedge Clk);
    chk("busy_before_flush", Busy, 1);
    Flush = 1;
    @(negedge Clk);
    Flush = 0;
    chk("busy_after_flush", Busy, 0);
    repeat (40) @(negedge Clk);
    chk("flush_hi", HI, 32'h11);
    chk("flush_lo", LO, 32'h22);
    Start = 1;
    Flush = 1;
    @(negedge Clk);
    Start = 0;
    Flush = 0;
    chk("flush_drops_start", Busy, 0);
    Op = 2'b10;
    A = 1000;
    B = 7;
    Start = 1;
    @(negedge Clk);
    Start = 0;
    repeat (15) @(negedge Clk);
    Rst_n = 0;
    #1;
    chk("midrst_hi", HI, 0);
    chk("midrst_lo", LO, 0);
    chk("midrst_busy", Busy, 0);
    chk("midrst_stall", Stall, 0);
    chk("midrst_done", Done, 0);
    chk("midrst_dbz", DivByZero, 0);
    @(negedge Clk);
    Rst_n = 1;
    repeat (40) @(negedge Clk);
    chk("midrst_stays_idle", Busy, 0);
    mf_test(2'b00, 32'd7, 32'hFFFF_FFFD);
    mf_test(2'b11, $urandom, $urandom | 32'd1);
    mt_test(32'd123, 32'd456, 32'hDEAD_BEEF, 32'd17);
    repeat (3) @(negedge Clk);
    chk("scoreboard_empty", 64'(scb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
